// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the CPU
// load/store path and a host loader, stalling the CPU while it waits.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_rdata, cpu_stall   CPU side
//   host_req/we/addr/wdata -> host_gnt, host_rvalid, host_rdata
//   mem_en/we/addr/wdata, mem_rdata                 RAM side
//
// Optional feature: define DMEM_ARB_HOST_BURST_EN to let the host keep
// tie priority for up to BURST consecutive grants (message loading).
module dmem_port_arbiter #(
  parameter int AW     = 6,
  parameter int RD_LAT = 1
`ifdef DMEM_ARB_HOST_BURST_EN
  ,
  parameter int BURST  = 4
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [31:0]   host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int LW = 2;

  typedef enum logic {
    S_IDLE,
    S_RD_WAIT
  } state_t;

  state_t        r_state;
  logic [LW-1:0] r_lat_cnt;
  logic          r_owner_host;
  logic          r_dvalid;
  logic [31:0]   r_cpu_rdata;
  logic [31:0]   r_host_rdata;

  logic w_can;
  logic w_cpu_pri;
  logic w_cpu_win;
  logic w_host_win;
  logic w_last_rd;
  logic w_cpu_data;

  // The data cycle (r_dvalid) blocks issue so a CPU load that is still
  // presenting its request is not re-issued.
  assign w_can      = ~rst & (r_state == S_IDLE) & ~r_dvalid;
  assign w_cpu_win  = w_can & cpu_req & (~host_req | w_cpu_pri);
  assign w_host_win = w_can & host_req & ~w_cpu_win;
  assign w_last_rd  = (r_state == S_RD_WAIT) &&
                      (r_lat_cnt == LW'(RD_LAT - 1));
  assign w_cpu_data = ~rst & r_dvalid & ~r_owner_host;

  assign cpu_stall   = cpu_req & ~((w_cpu_win & cpu_we) | w_cpu_data);
  assign cpu_rdata   = r_cpu_rdata;
  assign host_gnt    = w_host_win;
  assign host_rvalid = ~rst & r_dvalid & r_owner_host;
  assign host_rdata  = r_host_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      w_cpu_win: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      w_host_win: begin
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      default: ;
    endcase
  end

`ifdef DMEM_ARB_HOST_BURST_EN
  localparam int BW = $clog2(BURST + 1);

  logic [BW-1:0] r_burst;

  // CPU only wins a tie once the host has used its whole burst.
  assign w_cpu_pri = (r_burst == BW'(BURST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst <= '0;
    end else if (w_cpu_win) begin
      r_burst <= '0;
    end else if (w_host_win) begin
      if (r_burst != BW'(BURST))
        r_burst <= r_burst + 1'b1;
    end else if (!host_req) begin
      r_burst <= '0;
    end
  end
`else
  logic r_last_host;

  // Round-robin: the side not granted last wins a tie.
  assign w_cpu_pri = r_last_host;

  always_ff @(posedge clk) begin
    if (rst)
      r_last_host <= 1'b1;
    else if (w_cpu_win | w_host_win)
      r_last_host <= w_host_win;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_owner_host <= 1'b0;
      r_dvalid     <= 1'b0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      r_dvalid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if ((w_cpu_win | w_host_win) & ~mem_we) begin
            r_state      <= S_RD_WAIT;
            r_lat_cnt    <= '0;
            r_owner_host <= w_host_win;
          end
        end
        S_RD_WAIT: begin
          // Capture the RAM word here; it is presented to the owner
          // from registers in the following (data) cycle.
          if (w_last_rd) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= '0;
            r_dvalid  <= 1'b1;
            if (r_owner_host)
              r_host_rdata <= mem_rdata;
            else
              r_cpu_rdata <= mem_rdata;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
